// File: rtl/csr_timer_regblock_if.sv
// ============================================================================
// csr_timer_regblock_if : single-cycle request/response bus into the CSR block
// Revision 1.0
// ============================================================================
`default_nettype none

interface csr_timer_regblock_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                      bus_req;
    logic                      bus_req_is_wr;
    logic [ADDR_WIDTH-1:0]     bus_addr;
    logic [DATA_WIDTH-1:0]     bus_wr_data;
    logic [DATA_WIDTH/8-1:0]   bus_wr_biten;
    logic [DATA_WIDTH-1:0]     bus_rd_data;
    logic                      bus_ready;
    logic                      bus_err;

    modport master (
        output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        input  bus_rd_data, bus_ready, bus_err
    );

    modport slave (
        input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
        output bus_rd_data, bus_ready, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/csr_timer_regblock.sv
// ============================================================================
// csr_timer_regblock : zero-wait-state CSR map with a one-shot countdown timer.
// Optional SCRATCH register enabled by macro CSR_TIMER_SCRATCH_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module csr_timer_regblock #(
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'hC5A0_0001
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    csr_timer_regblock_if.slave    bus,
    output logic                   irq,
    output logic                   timer_busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         NBYTES  = DATA_WIDTH / 8;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] w_count_nxt;
    logic [DATA_WIDTH-1:0] r_load;
    logic                  r_irq_en;
    logic                  r_done;
    logic                  r_ovr;
    logic                  w_done_set;
    logic                  w_ovr_set;
`ifdef CSR_TIMER_SCRATCH_EN
    logic [DATA_WIDTH-1:0] r_scratch;
`endif

    logic [2:0]            w_idx;
    logic                  w_addr_hi;
    logic                  w_unmapped;
    logic                  w_bad;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_stat;
    logic                  w_wr_load;
    logic                  w_start;
    logic                  w_abort;
    logic [DATA_WIDTH-1:0] w_rd;

    function automatic logic [DATA_WIDTH-1:0] be_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    assign w_idx = bus.bus_addr[4:2];

    generate
        if (ADDR_WIDTH > 5) begin : g_addr_hi
            assign w_addr_hi = |bus.bus_addr[ADDR_WIDTH-1:5];
        end else begin : g_addr_exact
            assign w_addr_hi = 1'b0;
        end
    endgenerate

`ifdef CSR_TIMER_SCRATCH_EN
    assign w_unmapped = (w_idx == 3'd6) || (w_idx == 3'd7);
`else
    assign w_unmapped = (w_idx == 3'd4) || (w_idx == 3'd6) || (w_idx == 3'd7);
`endif

    // COUNT (3) and ID (5) are read-only; writing them is an error.
    assign w_bad = (bus.bus_addr[1:0] != 2'b00) || w_addr_hi || w_unmapped ||
                   (bus.bus_req_is_wr && ((w_idx == 3'd3) || (w_idx == 3'd5)));

    assign bus.bus_ready = bus.bus_req;
    assign bus.bus_err   = bus.bus_req & w_bad;

    assign w_wr      = bus.bus_req & bus.bus_req_is_wr & ~w_bad;
    assign w_wr_ctrl = w_wr & bus.bus_wr_biten[0] & (w_idx == 3'd0);
    assign w_wr_stat = w_wr & bus.bus_wr_biten[0] & (w_idx == 3'd1);
    assign w_wr_load = w_wr & (w_idx == 3'd2);
    assign w_start   = w_wr_ctrl & bus.bus_wr_data[0];
    assign w_abort   = w_wr_ctrl & bus.bus_wr_data[2];

    always_comb begin
        w_rd = '0;
        if (bus.bus_req && !bus.bus_req_is_wr && !w_bad) begin
            case (w_idx)
                3'd0: w_rd[1] = r_irq_en;
                3'd1: begin
                    w_rd[0] = r_done;
                    w_rd[1] = r_ovr;
                    w_rd[8] = (r_state == ST_RUN);
                end
                3'd2: w_rd = r_load;
                3'd3: w_rd = r_count;
`ifdef CSR_TIMER_SCRATCH_EN
                3'd4: w_rd = r_scratch;
`endif
                3'd5: w_rd = ID_VALUE;
                default: w_rd = '0;
            endcase
        end
    end

    assign bus.bus_rd_data = w_rd;

    // ABORT takes priority over START issued in the same write.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_set  = 1'b0;
        w_ovr_set   = 1'b0;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (r_load == '0) begin
                            w_done_set = 1'b1;
                        end else begin
                            w_count_nxt = r_load;
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    w_ovr_set = w_start;
                    if (r_count <= 1) begin
                        w_count_nxt = '0;
                        w_done_set  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_count_nxt = r_count - 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_load   <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
`ifdef CSR_TIMER_SCRATCH_EN
            r_scratch <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_wr_ctrl) r_irq_en <= bus.bus_wr_data[1];
            // A hardware set beats a simultaneous W1C.
            r_done <= (r_done & ~(w_wr_stat & bus.bus_wr_data[0])) | w_done_set;
            r_ovr  <= (r_ovr  & ~(w_wr_stat & bus.bus_wr_data[1])) | w_ovr_set;
            if (w_wr_load) r_load <= be_merge(r_load, bus.bus_wr_data, bus.bus_wr_biten);
`ifdef CSR_TIMER_SCRATCH_EN
            if (w_wr && (w_idx == 3'd4))
                r_scratch <= be_merge(r_scratch, bus.bus_wr_data, bus.bus_wr_biten);
`endif
        end
    end

    assign irq        = r_irq_en & (r_done | r_ovr);
    assign timer_busy = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_csr_timer_regblock.sv
// ============================================================================
// tb_csr_timer_regblock : directed self-checking bench for csr_timer_regblock
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_csr_timer_regblock;

    logic clk;
    logic rst_n;
    logic irq;
    logic timer_busy;

    int n_pass;
    int n_total;

    logic [31:0] rd;
    logic        err;
    logic        rdy;

    csr_timer_regblock_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) u_bus ();

    csr_timer_regblock #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .ID_VALUE   (32'hC5A0_0001)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (u_bus),
        .irq        (irq),
        .timer_busy (timer_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus cycle: drive at negedge, sample combinational response, end at posedge.
    task automatic acc(input logic wr, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        @(negedge clk);
        u_bus.bus_req       = 1'b1;
        u_bus.bus_req_is_wr = wr;
        u_bus.bus_addr      = a;
        u_bus.bus_wr_data   = d;
        u_bus.bus_wr_biten  = be;
        #1;
        rd  = u_bus.bus_rd_data;
        err = u_bus.bus_err;
        rdy = u_bus.bus_ready;
        @(posedge clk);
        #1;
        u_bus.bus_req       = 1'b0;
        u_bus.bus_req_is_wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        acc(1'b0, a, 32'h0, 4'h0);
        chk(tag, rd, exp);
        chk({tag, "_err"}, {31'b0, err}, 32'h0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        u_bus.bus_req       = 1'b0;
        u_bus.bus_req_is_wr = 1'b0;
        u_bus.bus_addr      = '0;
        u_bus.bus_wr_data   = '0;
        u_bus.bus_wr_biten  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("idle_ready", {31'b0, u_bus.bus_ready}, 32'h0);
        chk("idle_rd", u_bus.bus_rd_data, 32'h0);
        rd_chk("rst_ctrl", 5'h00, 32'h0);
        chk("rst_ready", {31'b0, rdy}, 32'h1);
        rd_chk("rst_status", 5'h04, 32'h0);
        rd_chk("rst_load", 5'h08, 32'h0);
        rd_chk("rst_count", 5'h0C, 32'h0);
`ifdef CSR_TIMER_SCRATCH_EN
        rd_chk("rst_scratch", 5'h10, 32'h0);
`endif
        rd_chk("rst_id", 5'h14, 32'hC5A0_0001);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_busy", {31'b0, timer_busy}, 32'h0);

        // LOAD=3, START with IRQ_EN
        acc(1'b1, 5'h08, 32'd3, 4'hF);
        acc(1'b1, 5'h00, 32'h3, 4'hF);
        chk("run_busy0", {31'b0, timer_busy}, 32'h1);
        rd_chk("cnt3", 5'h0C, 32'd3);
        rd_chk("cnt2", 5'h0C, 32'd2);
        chk("run_busy2", {31'b0, timer_busy}, 32'h1);
        chk("run_irq_early", {31'b0, irq}, 32'h0);
        rd_chk("cnt1", 5'h0C, 32'd1);
        chk("done_busy", {31'b0, timer_busy}, 32'h0);
        chk("done_irq", {31'b0, irq}, 32'h1);
        rd_chk("cnt0", 5'h0C, 32'd0);
        rd_chk("done_status", 5'h04, 32'h1);
        rd_chk("ctrl_irqen", 5'h00, 32'h2);
        acc(1'b1, 5'h04, 32'h1, 4'hF);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        rd_chk("w1c_status", 5'h04, 32'h0);

        // Overrun then abort
        acc(1'b1, 5'h08, 32'd10, 4'hF);
        acc(1'b1, 5'h00, 32'h1, 4'hF);
        acc(1'b1, 5'h00, 32'h1, 4'hF);
        rd_chk("ovr_cnt", 5'h0C, 32'd9);
        rd_chk("ovr_status", 5'h04, 32'h102);
        acc(1'b1, 5'h00, 32'h5, 4'hF);
        chk("abort_busy", {31'b0, timer_busy}, 32'h0);
        rd_chk("abort_cnt", 5'h0C, 32'd0);
        rd_chk("abort_status", 5'h04, 32'h2);
        acc(1'b1, 5'h04, 32'h2, 4'hF);
        rd_chk("ovr_clr", 5'h04, 32'h0);

        // START with LOAD=0 sets DONE immediately
        acc(1'b1, 5'h08, 32'd0, 4'hF);
        acc(1'b1, 5'h00, 32'h1, 4'hF);
        chk("zero_busy", {31'b0, timer_busy}, 32'h0);
        rd_chk("zero_status", 5'h04, 32'h1);
        acc(1'b1, 5'h04, 32'h1, 4'hF);

        // CTRL write without lane 0 is silently ignored
        acc(1'b1, 5'h00, 32'h1, 4'hE);
        chk("nolane_err", {31'b0, err}, 32'h0);
        rd_chk("nolane_status", 5'h04, 32'h0);

        // SCRATCH byte enables
`ifdef CSR_TIMER_SCRATCH_EN
        acc(1'b1, 5'h10, 32'h1122_3344, 4'hF);
        acc(1'b1, 5'h10, 32'hAABB_CCDD, 4'b0101);
        chk("scr_wr_err", {31'b0, err}, 32'h0);
        rd_chk("scr_merge", 5'h10, 32'h11BB_33DD);
`else
        acc(1'b1, 5'h10, 32'hAABB_CCDD, 4'hF);
        chk("scr_wr_err", {31'b0, err}, 32'h1);
        acc(1'b0, 5'h10, 32'h0, 4'h0);
        chk("scr_rd_err", {31'b0, err}, 32'h1);
        chk("scr_rd_data", rd, 32'h0);
`endif

        // Error responses
        acc(1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF);
        chk("err_cnt_wr", {31'b0, err}, 32'h1);
        acc(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF);
        chk("err_id_wr", {31'b0, err}, 32'h1);
        acc(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF);
        chk("err_unmap_wr", {31'b0, err}, 32'h1);
        acc(1'b0, 5'h06, 32'h0, 4'h0);
        chk("err_mis_rd", {31'b0, err}, 32'h1);
        chk("err_mis_data", rd, 32'h0);
        chk("err_ready", {31'b0, rdy}, 32'h1);
        acc(1'b1, 5'h0A, 32'hFFFF_FFFF, 4'hF);
        chk("err_mis_wr", {31'b0, err}, 32'h1);
        rd_chk("err_load", 5'h08, 32'h0);
        rd_chk("err_cnt", 5'h0C, 32'h0);
        rd_chk("err_id", 5'h14, 32'hC5A0_0001);
        chk("err_busy", {31'b0, timer_busy}, 32'h0);

        // DONE set coinciding with W1C of DONE
        acc(1'b1, 5'h08, 32'd2, 4'hF);
        acc(1'b1, 5'h00, 32'h1, 4'hF);
        rd_chk("coinc_cnt", 5'h0C, 32'd2);
        acc(1'b1, 5'h04, 32'h1, 4'hF);
        rd_chk("coinc_status", 5'h04, 32'h1);
        acc(1'b1, 5'h04, 32'h1, 4'hF);
        rd_chk("coinc_clr", 5'h04, 32'h0);

        // Reset mid-RUN with COUNT=5; a write during reset is dropped
        acc(1'b1, 5'h08, 32'd5, 4'hF);
        acc(1'b1, 5'h00, 32'h3, 4'hF);
        chk("pre_rst_busy", {31'b0, timer_busy}, 32'h1);
        rst_n = 1'b0;
        acc(1'b1, 5'h08, 32'h55, 4'hF);
        chk("rst_wr_ready", {31'b0, rdy}, 32'h1);
        rst_n = 1'b1;
        chk("mrst_busy", {31'b0, timer_busy}, 32'h0);
        chk("mrst_irq", {31'b0, irq}, 32'h0);
        rd_chk("mrst_ctrl", 5'h00, 32'h0);
        rd_chk("mrst_status", 5'h04, 32'h0);
        rd_chk("mrst_load", 5'h08, 32'h0);
        rd_chk("mrst_count", 5'h0C, 32'h0);
`ifdef CSR_TIMER_SCRATCH_EN
        rd_chk("mrst_scratch", 5'h10, 32'h0);
`endif
        repeat (8) @(posedge clk);
        #1;
        rd_chk("mrst_nodone", 5'h04, 32'h0);
        chk("mrst_irq_late", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
